wb_block_reader: RTL
====================

# wb_block_reader

Wishbone master that reads a contiguous block of 32-bit words from a Wishbone slave memory and delivers them, in address order, on a valid/ready stream through an internal FIFO. It sits between a memory slave on the shared `wshb_if` bus and a streaming consumer such as a display or checksum unit. A command (base address, word count, start pulse) launches one transfer; `done` pulses when the last word has left the FIFO.

## Interface
Parameters:
- `FIFO_DEPTH`, 16: output FIFO depth in words, power of two, ≥ 2.
- `LEN_W`, 16: width of the word-count field.

Ports:
- `wb_m.clk`, in, 1: single clock. Every flop is clocked on the rising edge.
- `wb_m.rst`, in, 1: asynchronous, active-high reset.
- `wb_m`, `wshb_if.master`: drives `cyc`, `stb`, `we`, `adr`, `sel`, `dat_ms`, `cti`, `bte`; samples `dat_sm` and `ack`.
- `start`, in, 1: one-cycle command strobe. Sampled only in IDLE.
- `base_adr`, in, 32: byte start address. Bits [1:0] are ignored and forced to 0.
- `n_words`, in, `LEN_W`: number of words to read.
- `busy`, out, 1: high from command accept until `done`.
- `done`, out, 1: one-cycle completion pulse.
- `m_data`, out, 32: stream data (FIFO head).
- `m_valid`, out, 1: stream valid.
- `m_ready`, in, 1: stream ready. A word transfers when `m_valid && m_ready`.

## Operation
- Bus drive values that never change: `we`=0, `sel`=4'hF, `dat_ms`=0, `bte`=2'b00.
- Internal state:
  - `cur_adr` (32 b): advances by 4 on each `ack` and wraps modulo 2^32.
  - `remaining` (`LEN_W` b): decrements by 1 on each `ack`.
  - `fifo_cnt`: number of words held in the FIFO.
- FSM states: IDLE, READ, DRAIN.
- **IDLE**: `cyc`=`stb`=0.
  - `start` with `n_words`≠0: latch `cur_adr` and `remaining`, go to READ.
  - `start` with `n_words`=0: pulse `done` on the next cycle, stay in IDLE, issue no bus cycle.
- **READ**:
  - `cyc`=`stb`=1 whenever `fifo_cnt` < `FIFO_DEPTH`, using the current-cycle count; a same-cycle pop does not count. Otherwise both are 0.
  - `adr`=`cur_adr`.
  - On `ack`: push `dat_sm` into the FIFO, advance `cur_adr`, decrement `remaining`.
  - On the `ack` that brings `remaining` to 0: go to DRAIN, with `cyc`/`stb` low from the next cycle.
- **DRAIN**: `cyc`=`stb`=0. When the FIFO is empty, assert `done` for one cycle and return to IDLE.
- `busy` is high in READ and DRAIN.
- `start` while `busy` is ignored.
- Stream side:
  - `m_valid` = (`fifo_cnt`≠0).
  - Simultaneous push and pop leaves `fifo_cnt` unchanged.
  - A stalled `m_ready` backpressures the bus through the FIFO-full gate; no data is ever dropped.
- Reset at any time:
  - Immediately forces `cyc`=`stb`=0, `cti`=0, `adr`=0, `busy`=0, `done`=0, `m_valid`=0, `m_data`=0.
  - Empties the FIFO and returns the FSM to IDLE.
  - Any in-flight bus cycle is abandoned.

## Timing
- Classic handshake: `stb`/`adr` are held stable until `ack`. The next request may be presented in the cycle after `ack`.
- Against a memory slave that acks reads one cycle after `stb` and never acks two consecutive cycles, throughput is 1 word per 2 cycles.
- A word acked in cycle N appears with `m_valid` in cycle N+1.
- `done` is asserted the cycle after the FIFO becomes empty in DRAIN.
- Minimum command-to-first-`stb` latency is 1 cycle.

## Configuration
- `WB_BLOCK_READER_BURST_EN` defined:
  - READ issues incrementing bursts with `cti`=3'b010 and `bte`=2'b00.
  - A segment may start only when the FIFO has at least one free slot. Its length is min(`remaining`, free slots at segment start), counting this cycle's pop.
  - The last beat of each segment carries `cti`=3'b111, then `cyc` drops for one cycle before the next segment.
  - `adr` advances on every `ack`.
- `WB_BLOCK_READER_BURST_EN` undefined: `cti`=3'b000 always, classic single cycles only.

## Structure
- Package `wb_reader_pkg` holds:
  - The FSM state enum.
  - The constants `CTI_CLASSIC`=3'b000, `CTI_INCR`=3'b010, `CTI_END`=3'b111.
- Sub-module `wb_reader_fifo` is a synchronous FIFO with parameter `DEPTH` and width 32. It exposes `push`, `pop`, `din`, `dout`, `cnt`, `empty`, `full`, and is reset by `wb_m.rst`.
- The top level contains the FSM, the address/count registers and the bus drive.

## Test plan
- Slave memory preloaded with word i = 32'hA500_0000+i; `base_adr`=0x100, `n_words`=8, `m_ready`=1 → stream emits 0xA500_0040..0xA500_0047 in order, then one `done` pulse and `busy` low.
- `n_words`=0 with `start` → `done` the next cycle, `cyc` never asserted.
- `m_ready`=0 for 40 cycles during a 32-word read with `FIFO_DEPTH`=16 → exactly 16 acks then `stb` low. After `m_ready`=1 all 32 words arrive with no loss or duplication.
- `base_adr`=0xFFFF_FFF8, `n_words`=4 → bus addresses 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0000_0000, 0x0000_0004.
- Assert `rst` mid-transfer after 3 acks → `cyc`/`stb`/`m_valid` drop in the same cycle. A new 2-word command afterwards completes normally.
- With `WB_BLOCK_READER_BURST_EN`, a 4-word read from an empty FIFO → one segment with `cti` sequence 010, 010, 010, 111.

Source files
------------

// File: rtl/wb_reader_pkg.sv
// Shared types and constants for the Wishbone block reader.
package wb_reader_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    localparam logic [2:0] CTI_CLASSIC = 3'b000;
    localparam logic [2:0] CTI_INCR    = 3'b010;
    localparam logic [2:0] CTI_END     = 3'b111;

endpackage

// File: rtl/wshb_if.sv
// Shared Wishbone bus: 32-bit data/address, registered-feedback cycle tags.
interface wshb_if (
    input logic clk,
    input logic rst
);
    logic        cyc;
    logic        stb;
    logic        we;
    logic [31:0] adr;
    logic [3:0]  sel;
    logic [31:0] dat_ms;
    logic [31:0] dat_sm;
    logic        ack;
    logic [2:0]  cti;
    logic [1:0]  bte;

    modport master (
        input  clk, rst, dat_sm, ack,
        output cyc, stb, we, adr, sel, dat_ms, cti, bte
    );

    modport slave (
        input  clk, rst, cyc, stb, we, adr, sel, dat_ms, cti, bte,
        output dat_sm, ack
    );
endinterface

// File: rtl/wb_reader_fifo.sv
// 32-bit synchronous FIFO; head reads as zero when empty so the stream output is clean after reset.
module wb_reader_fifo #(
    parameter int DEPTH = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic                   pop,
    input  logic [31:0]            din,
    output logic [31:0]            dout,
    output logic [$clog2(DEPTH):0] cnt,
    output logic                   empty,
    output logic                   full
);
    localparam int AW = $clog2(DEPTH);

    logic [31:0]   mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          wr_en;
    logic          rd_en;

    assign empty = (cnt == '0);
    assign full  = (cnt == (AW+1)'(DEPTH));
    assign wr_en = push && !full;
    assign rd_en = pop && !empty;
    assign dout  = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + AW'(1);
            if (rd_en) rd_ptr <= rd_ptr + AW'(1);
            case ({wr_en, rd_en})
                2'b10:   cnt <= cnt + (AW+1)'(1);
                2'b01:   cnt <= cnt - (AW+1)'(1);
                default: cnt <= cnt;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/wb_block_reader.sv
// Wishbone master reading a word block into a FIFO-backed valid/ready stream.
// Define WB_BLOCK_READER_BURST_EN for incrementing-burst segments instead of classic cycles.
module wb_block_reader
    import wb_reader_pkg::*;
#(
    parameter int FIFO_DEPTH = 16,
    parameter int LEN_W      = 16
) (
    wshb_if.master          wb_m,
    input  logic            start,
    input  logic [31:0]     base_adr,
    input  logic [LEN_W-1:0] n_words,
    output logic            busy,
    output logic            done,
    output logic [31:0]     m_data,
    output logic            m_valid,
    input  logic            m_ready
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic             clk;
    logic             rst;
    state_t           state;
    logic [31:0]      cur_adr;
    logic [LEN_W-1:0] remaining;
    logic             done_r;
    logic             req;
    logic             push;
    logic             pop;
    logic [CW-1:0]    fifo_cnt;
    logic             fifo_empty;
    logic             fifo_full;

    assign clk = wb_m.clk;
    assign rst = wb_m.rst;

    assign wb_m.we     = 1'b0;
    assign wb_m.sel    = 4'hF;
    assign wb_m.dat_ms = '0;
    assign wb_m.bte    = 2'b00;
    assign wb_m.cyc    = req;
    assign wb_m.stb    = req;
    assign wb_m.adr    = cur_adr;

    assign push    = req && wb_m.ack;
    assign m_valid = (fifo_cnt != '0);
    assign pop     = m_valid && m_ready;
    assign busy    = (state != IDLE);
    assign done    = done_r;

`ifdef WB_BLOCK_READER_BURST_EN
    logic [LEN_W-1:0] seg_left;
    logic [LEN_W-1:0] seg_len;
    logic [LEN_W-1:0] first_len;
    int unsigned      free_slots;

    always_comb begin
        free_slots = 32'(FIFO_DEPTH) - 32'(fifo_cnt) + (pop ? 32'd1 : 32'd0);
        seg_len    = (32'(remaining) < free_slots) ? remaining : LEN_W'(free_slots);
        first_len  = (32'(n_words) < 32'(FIFO_DEPTH)) ? n_words : LEN_W'(FIFO_DEPTH);
    end

    assign req      = (state == READ) && (seg_left != '0);
    assign wb_m.cti = req ? ((seg_left == LEN_W'(1)) ? CTI_END : CTI_INCR) : CTI_CLASSIC;

    // seg_left==0 inside READ is the one-cycle gap where the next segment is sized
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            seg_left <= '0;
        end else if (state == IDLE) begin
            if (start && n_words != '0) seg_left <= first_len;
        end else if (state == READ) begin
            if (push)
                seg_left <= seg_left - LEN_W'(1);
            else if (seg_left == '0 && (!fifo_full || pop))
                seg_left <= seg_len;
        end
    end
`else
    assign req      = (state == READ) && !fifo_full;
    assign wb_m.cti = CTI_CLASSIC;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cur_adr   <= '0;
            remaining <= '0;
            done_r    <= 1'b0;
        end else begin
            done_r <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        if (n_words != '0) begin
                            cur_adr   <= base_adr & 32'hFFFF_FFFC;
                            remaining <= n_words;
                            state     <= READ;
                        end else begin
                            done_r <= 1'b1;
                        end
                    end
                end
                READ: begin
                    if (push) begin
                        cur_adr   <= cur_adr + 32'd4;
                        remaining <= remaining - LEN_W'(1);
                        if (remaining == LEN_W'(1)) state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (fifo_empty) begin
                        done_r <= 1'b1;
                        state  <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    wb_reader_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .din   (wb_m.dat_sm),
        .dout  (m_data),
        .cnt   (fifo_cnt),
        .empty (fifo_empty),
        .full  (fifo_full)
    );

endmodule
